// File: rtl/ex_mem_ctl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_ctl_pkg                                            |
// | Purpose  : Shared constants, the per-edge action type and its        |
// |            priority decoder for the EX/MEM pipeline register.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ex_mem_ctl_pkg;

  // Reset is active-low for this block.
  localparam logic       c_rst_enable    = 1'b0;
  localparam logic       c_write_enable  = 1'b1;
  localparam logic       c_write_disable = 1'b0;
  localparam logic [4:0] c_nop_reg_addr  = 5'd0;
  localparam logic [31:0] c_zero_word    = 32'h0000_0000;
  localparam logic       c_stop          = 1'b1;
  localparam logic       c_no_stop       = 1'b0;
  localparam logic [7:0] c_exe_nop_op    = 8'h00;

  // What the register does on a given rising edge.
  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_BUBBLE  = 3'd2,
    ACT_ADVANCE = 3'd3,
    ACT_HOLD    = 3'd4
  } action_e;

  // Priority: reset > flush > bubble > advance > hold.
  // The illegal combination (own stage running, MEM stopped) falls into
  // advance because only stall_cur is consulted there.
  function automatic action_e decode_action(
    input logic rst,
    input logic flush,
    input logic stall_cur,
    input logic stall_nxt
  );
    if (rst == c_rst_enable)
      return ACT_RESET;
    else if (flush)
      return ACT_FLUSH;
    else if (stall_cur == c_stop && stall_nxt == c_no_stop)
      return ACT_BUBBLE;
    else if (stall_cur == c_no_stop)
      return ACT_ADVANCE;
    else
      return ACT_HOLD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_ctl_if                                             |
// | Purpose  : Bundle of the EX-side inputs, stall/flush control and the |
// |            MEM-side / feedback outputs of the EX/MEM register.       |
// |   slave  : the pipeline register (consumes ex_*, drives mem_*)       |
// |   master : the surrounding pipeline (drives ex_*, consumes mem_*)    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface ex_mem_ctl_if #(
  parameter int DATA_W  = 32,
  parameter int REGA_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 2,
  parameter int BCNT_W  = 16
);
  logic [STALL_W-1:0]  stall;
  logic                flush;

  logic [REGA_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [DATA_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_reg2;
  logic [2*DATA_W-1:0] hilo_i;
  logic [CNT_W-1:0]    cnt_i;

  logic [REGA_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [ALUOP_W-1:0]  mem_aluop;
  logic [DATA_W-1:0]   mem_mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
  logic [2*DATA_W-1:0] hilo_o;
  logic [CNT_W-1:0]    cnt_o;
  logic [BCNT_W-1:0]   bubble_cnt;

  modport slave (
    input  stall, flush,
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
    input  ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o, bubble_cnt
  );

  modport master (
    output stall, flush,
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
    output ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_ctl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sat_counter                                               |
// | Purpose  : Up counter that sticks at all-ones instead of wrapping.   |
// |   clk   in  clock, rising edge                                       |
// |   clr   in  synchronous clear (wins over inc)                        |
// |   inc   in  count up by one                                          |
// |   count out current value                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic [W-1:0]      count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr)
      r_count <= '0;
    else if (inc && (r_count != {W{1'b1}}))
      r_count <= r_count + W'(1);
  end

  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/ex_mem_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_ctl                                                |
// | Purpose  : EX/MEM pipeline register with stall, bubble and flush.    |
// |            Also parks EX's multi-cycle accumulator while EX stalls   |
// |            and counts bubbles pushed into MEM.                       |
// |   clk  in  clock, rising edge                                        |
// |   rst  in  synchronous reset, active-low                             |
// |   bus  slave modport: stall/flush, ex_* in, mem_* / hilo_o / cnt_o / |
// |        bubble_cnt out (all outputs registered)                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ex_mem_ctl
  import ex_mem_ctl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REGA_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,   // STAGE+1 is the MEM bit; keep STAGE < STALL_W-1
  parameter int CNT_W   = 2,
  parameter int BCNT_W  = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ex_mem_ctl_if.slave bus
);
  action_e w_action;
  logic    w_clear_mem;
  logic    w_unused;

  logic [REGA_W-1:0]   r_mem_wd;
  logic                r_mem_wreg;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_whilo;
  logic [DATA_W-1:0]   r_mem_hi;
  logic [DATA_W-1:0]   r_mem_lo;
  logic [ALUOP_W-1:0]  r_mem_aluop;
  logic [DATA_W-1:0]   r_mem_mem_addr;
  logic [DATA_W-1:0]   r_mem_reg2;
  logic [2*DATA_W-1:0] r_hilo;
  logic [CNT_W-1:0]    r_cnt;

  always_comb begin
    w_action    = decode_action(rst, bus.flush, bus.stall[STAGE], bus.stall[STAGE+1]);
    // Reset, flush and bubble all present a NOP to MEM.
    w_clear_mem = (w_action == ACT_RESET) || (w_action == ACT_FLUSH) ||
                  (w_action == ACT_BUBBLE);
  end

  // Only two bits of the global stall vector matter to this stage.
  assign w_unused = ^bus.stall;

  always_ff @(posedge clk) begin
    if (w_clear_mem) begin
      r_mem_wd       <= REGA_W'(c_nop_reg_addr);
      r_mem_wreg     <= c_write_disable;
      r_mem_wdata    <= DATA_W'(c_zero_word);
      r_mem_whilo    <= c_write_disable;
      r_mem_hi       <= DATA_W'(c_zero_word);
      r_mem_lo       <= DATA_W'(c_zero_word);
      r_mem_aluop    <= ALUOP_W'(c_exe_nop_op);
      r_mem_mem_addr <= DATA_W'(c_zero_word);
      r_mem_reg2     <= DATA_W'(c_zero_word);
    end else if (w_action == ACT_ADVANCE) begin
      r_mem_wd       <= bus.ex_wd;
      r_mem_wreg     <= bus.ex_wreg;
      r_mem_wdata    <= bus.ex_wdata;
      r_mem_whilo    <= bus.ex_whilo;
      r_mem_hi       <= bus.ex_hi;
      r_mem_lo       <= bus.ex_lo;
      r_mem_aluop    <= bus.ex_aluop;
      r_mem_mem_addr <= bus.ex_mem_addr;
      r_mem_reg2     <= bus.ex_reg2;
    end
  end

  // Accumulator park: captured while EX is frozen behind a bubble, dropped
  // once EX advances (the multi-cycle op has completed) or is killed.
  always_ff @(posedge clk) begin
    case (w_action)
      ACT_RESET, ACT_FLUSH, ACT_ADVANCE: begin
        r_hilo <= '0;
        r_cnt  <= '0;
      end
      ACT_BUBBLE: begin
        r_hilo <= bus.hilo_i;
        r_cnt  <= bus.cnt_i;
      end
      default: ;
    endcase
  end

  sat_counter #(
    .W (BCNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .clr   (w_action == ACT_RESET),
    .inc   (w_action == ACT_BUBBLE),
    .count (bus.bubble_cnt)
  );

  assign bus.mem_wd       = r_mem_wd;
  assign bus.mem_wreg     = r_mem_wreg;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_whilo    = r_mem_whilo;
  assign bus.mem_hi       = r_mem_hi;
  assign bus.mem_lo       = r_mem_lo;
  assign bus.mem_aluop    = r_mem_aluop;
  assign bus.mem_mem_addr = r_mem_mem_addr;
  assign bus.mem_reg2     = r_mem_reg2;
  assign bus.hilo_o       = r_hilo;
  assign bus.cnt_o        = r_cnt;
endmodule
`default_nettype wire

// File: doc/ex_mem_ctl.md
Name: ex_mem_ctl

Overview:
- Parametrised EX/MEM pipeline register with stall, bubble and flush control.
- Carries the register-write, HI/LO-write and load/store fields from EX to MEM.
- Holds EX's multi-cycle accumulator state (madd/msub partial product, step count) while EX is stalled.
- Counts bubbles inserted into MEM in a saturating counter, for debug visibility.

Parameters:
- DATA_W, 32, width of data, address, HI and LO words
- REGA_W, 5, register-file address width
- ALUOP_W, 8, ALU/memory opcode width
- STALL_W, 6, width of the global stall vector
- STAGE, 3, index of this stage's bit in stall; STAGE+1 is the downstream (MEM) bit; must be < STALL_W-1
- CNT_W, 2, multi-cycle step counter width
- BCNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-low (rst==0 at a clk rising edge resets)
- stall  in  STALL_W  global stall vector; 1 = stop
- flush  in  1  exception flush; 1 = kill the stage contents
- ex_wd  in  REGA_W  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  register write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi  in  DATA_W  HI write value
- ex_lo  in  DATA_W  LO write value
- ex_aluop  in  ALUOP_W  opcode for MEM
- ex_mem_addr  in  DATA_W  load/store address
- ex_reg2  in  DATA_W  store data
- hilo_i  in  2*DATA_W  EX accumulator partial result
- cnt_i  in  CNT_W  EX multi-cycle step
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  same widths as inputs  registered copies of the ex_* inputs
- hilo_o  out  2*DATA_W  held accumulator, fed back to EX
- cnt_o  out  CNT_W  held step, fed back to EX
- bubble_cnt  out  BCNT_W  saturating count of bubbles inserted

Behaviour:
- All outputs are registered, updated on clk rising edge only. Latency EX->MEM is 1 cycle.
- Priority per edge: reset > flush > bubble > advance > hold.
- Reset (rst==0):
  - mem_wd = NOP register address (0); mem_wreg = 0, mem_whilo = 0.
  - All data outputs, mem_aluop (NOP opcode, 0), hilo_o, cnt_o and bubble_cnt = 0.
- Flush (flush==1): all mem_* outputs, hilo_o and cnt_o are set to their reset values. bubble_cnt is unchanged. Flush overrides any stall value.
- Bubble (stall[STAGE]==1 and stall[STAGE+1]==0):
  - mem_* outputs are set to their reset values, so MEM sees a NOP.
  - hilo_o <= hilo_i and cnt_o <= cnt_i.
  - bubble_cnt increments by 1 and saturates at all-ones; it does not wrap.
- Advance (stall[STAGE]==0):
  - Every mem_* output <= its ex_* input.
  - hilo_o and cnt_o are cleared to 0, because the multi-cycle op has completed.
- Hold (stall[STAGE]==1 and stall[STAGE+1]==1): all outputs keep their values, including hilo_o, cnt_o and bubble_cnt.
- stall[STAGE]==0 with stall[STAGE+1]==1 is illegal (the stall controller never produces it). The register treats it as advance. The bench asserts it never occurs.
- Reset and flush asserted together: reset result, which also clears bubble_cnt.
- Reset mid multi-cycle op: accumulator state is lost; no recovery is required.

Decomposition:
- Shared defines header holds: RstEnable (1'b0 for this block), WriteEnable/WriteDisable, NOPRegAddr, ZeroWord, Stop/NoStop, EXE_NOP_OP.
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; output count, saturating), used for bubble_cnt. Everything else is flat.

Test Plan:
- Reset with rst=0 for 2 cycles, inputs nonzero (ex_wd=5'd7, ex_wdata=32'hDEADBEEF) -> all outputs 0 on both edges; mem_wd=0.
- Release rst; stall=0; drive ex_wd=3, ex_wreg=1, ex_wdata=32'h1234_5678, ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB -> values appear on mem_* exactly 1 edge later; hilo_o=0, cnt_o=0.
- stall=6'b001111 (bit3=1, bit4=0) for 2 cycles, hilo_i=64'h1_0000_0002, cnt_i=1 -> mem_wreg=0 and mem_wd=0 each cycle; hilo_o=64'h1_0000_0002, cnt_o=1; bubble_cnt=2.
- stall=6'b011111 (hold) after an advance with mem_wdata=32'h55 -> mem_wdata stays 32'h55 and bubble_cnt is unchanged for 3 cycles. Then stall=0 -> new ex_* values are captured and hilo_o clears to 0.
- flush=1 while stall=6'b011111 and mem_wreg=1 -> next edge mem_wreg=0, hilo_o=0, cnt_o=0, bubble_cnt unchanged.
- BCNT_W=2 build, 5 consecutive bubbles -> bubble_cnt sequence 1,2,3,3,3. Then rst=0 -> bubble_cnt=0.
